// File: rtl/mycpu_muldiv.sv
// mycpu_muldiv: MIPS-style HI/LO multiply/divide unit.
// Iterative shift-add multiply and radix-2 restoring divide with 33-cycle latency;
// build-time macro MYCPU_MULDIV_FAST_MUL_EN switches MULT/MULTU to a single-cycle multiply.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, op, a, b       operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) and operands
//   cancel                pipeline flush, aborts an operation in flight
//   hi_we, lo_we, wdata   MTHI/MTLO writes, honoured only while idle with no start
//   busy, done            operation in flight / one-cycle completion pulse
//   hi, lo                architectural HI/LO registers
module mycpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned W2 = 2 * W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

`ifdef MYCPU_MULDIV_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
`else
    localparam logic FAST_MUL = 1'b0;
`endif

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [4:0]    cnt;
    logic          is_div_q;
    logic          neg_q;
    logic          rneg_q;
    logic          div0_q;
    logic [W2-1:0] acc;
    logic [W-1:0]  bmag;
    logic [W-1:0]  a_raw;

    logic          accept_c;
    logic          wr_ok_c;
    logic [W-1:0]  amag_c;
    logic [W-1:0]  bmag_c;
    logic [W:0]    msum_c;
    logic [W:0]    dtrial_c;
    logic [W2-1:0] mul_nx_c;
    logic [W2-1:0] div_nx_c;
    logic [W2-1:0] prod_c;
    logic [W2-1:0] prod_fix_c;
    logic [W-1:0]  res_hi_c;
    logic [W-1:0]  res_lo_c;

    // Request qualification; busy also covers the done cycle, so start is gated on it.
    always_comb begin
        accept_c = (state == S_IDLE) && start && !cancel && !busy;
        wr_ok_c  = (state == S_IDLE) && !start;
        amag_c   = (!op[0] && a[31]) ? (~a + W'(1)) : a;
        bmag_c   = (!op[0] && b[31]) ? (~b + W'(1)) : b;
    end

    // One shift-add multiply step: acc = {partial_hi, multiplier bits still to consume}.
    always_comb begin
        msum_c   = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, bmag} : (W+1)'(0));
        mul_nx_c = {msum_c, acc[W-1:1]};
    end

    // One restoring divide step: acc = {partial remainder, dividend/quotient bits}.
    always_comb begin
        dtrial_c = acc[W2-1:W-1] - {1'b0, bmag};
        if (dtrial_c[W]) begin
            div_nx_c = {acc[W2-2:0], 1'b0};
        end else begin
            div_nx_c = {dtrial_c[W-1:0], acc[W-2:0], 1'b1};
        end
    end

`ifdef MYCPU_MULDIV_FAST_MUL_EN
    // acc[31:0] still holds |a| because multiplies skip RUN in this build.
    always_comb prod_c = {{W{1'b0}}, acc[W-1:0]} * {{W{1'b0}}, bmag};
`else
    always_comb prod_c = acc;
`endif

    // Sign correction and divide-by-zero result selection for the FIX cycle.
    always_comb begin
        prod_fix_c = neg_q ? (~prod_c + W2'(1)) : prod_c;
        if (!is_div_q) begin
            res_hi_c = prod_fix_c[W2-1:W];
            res_lo_c = prod_fix_c[W-1:0];
        end else if (div0_q) begin
            res_hi_c = a_raw;
            res_lo_c = {W{1'b1}};
        end else begin
            res_hi_c = rneg_q ? (~acc[W2-1:W] + W'(1)) : acc[W2-1:W];
            res_lo_c = neg_q  ? (~acc[W-1:0] + W'(1))  : acc[W-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nx = (FAST_MUL && !op[1]) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_nx = S_IDLE;
                end else if (cnt == 5'd31) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 5'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            acc      <= W2'(0);
            bmag     <= W'(0);
            a_raw    <= W'(0);
            hi       <= W'(0);
            lo       <= W'(0);
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // busy lags the state by one cycle so it spans the done cycle.
            busy <= (state != S_IDLE);
            done <= (state == S_FIX) && !cancel;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        cnt      <= 5'd0;
                        is_div_q <= op[1];
                        neg_q    <= !op[0] && (a[31] ^ b[31]);
                        rneg_q   <= !op[0] && op[1] && a[31];
                        div0_q   <= op[1] && (b == W'(0));
                        acc      <= {{W{1'b0}}, amag_c};
                        bmag     <= bmag_c;
                        a_raw    <= a;
                    end
                    if (wr_ok_c && hi_we) begin
                        hi <= wdata;
                    end
                    if (wr_ok_c && lo_we) begin
                        lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (!cancel) begin
                        cnt <= cnt + 5'd1;
                        acc <= is_div_q ? div_nx_c : mul_nx_c;
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        hi <= res_hi_c;
                        lo <= res_lo_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mycpu_muldiv.sv
// Scoreboard bench for mycpu_muldiv: driver pushes expected HI/LO and completion cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mycpu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef MYCPU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    mycpu_muldiv dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic, MIPS divide-by-zero convention.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: model = 64'(sx * sy);
            2'b01: model = ux * uy;
            2'b10: begin
                if (y == 32'd0) begin
                    model = {x, 32'hFFFFFFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) model = {x, 32'hFFFFFFFF};
                else            model = {x % y, x / y};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done high with empty scoreboard at cycle %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("result_hi", 64'(hi), 64'(mon_e.hi));
                check("result_lo", 64'(lo), 64'(mon_e.lo));
                check("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Issue one operation; returns with n = edge N that sampled start (cyc == N on return).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_it, output int n);
        int          guard;
        logic [63:0] r;
        exp_t        e;
        guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: busy=%b still high before issue", busy);
        end
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        n     = cyc + 1;
        if (expect_it) begin
            r     = model(o, x, y);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.due = n + (o[1] ? DIV_LAT : MUL_LAT);
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still outstanding", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        issue(o, x, y, 1'b1, n);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          sel;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = 32'd0;
        b      = 32'd0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Simultaneous MTHI/MTLO.
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555AAAA;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo_hi", 64'(hi), 64'h5555AAAA);
        check("mthi_mtlo_lo", 64'(lo), 64'h5555AAAA);

        // Directed corner cases.
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        check("multu_max_lo", 64'(lo), 64'h00000001);
        run_op(2'b00, 32'hFFFFFFF9, 32'd3);
        check("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2);
        check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        run_op(2'b11, 32'd100, 32'd0);
        check("divu_zero_hi", 64'(hi), 64'd100);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", 64'(lo), 64'h80000000);
        run_op(2'b10, 32'hFFFFFFF9, 32'd0);
        run_op(2'b00, 32'h80000000, 32'h80000000);

        // Busy window for a divide.
        issue(2'b10, 32'd12345, 32'd17, 1'b1, n);
        check("div_busy_at_n", 64'(busy), 64'd0);
        @(negedge clk);
        check("div_busy_at_n1", 64'(busy), 64'd1);
        repeat (32) @(negedge clk);
        check("div_busy_at_n33", 64'(busy), 64'd1);
        @(negedge clk);
        check("div_busy_at_n34", 64'(busy), 64'd0);
        check("div_done_at_n34", 64'(done), 64'd0);
        drain();

        // Busy window for a multiply (build-specific latency).
        issue(2'b01, 32'd7, 32'd9, 1'b1, n);
        repeat (MUL_LAT) @(negedge clk);
        check("mul_busy_last", 64'(busy), 64'd1);
        @(negedge clk);
        check("mul_busy_after", 64'(busy), 64'd0);
        drain();

        // Second start while busy is dropped, not queued.
        issue(2'b11, 32'd1000, 32'd7, 1'b1, n);
        repeat (4) @(negedge clk);
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("ignored_start_lo", 64'(lo), 64'd142);

        // Cancel mid-divide; MTHI attempted while busy is ignored.
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h00001234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_preload", 64'(hi), 64'h1234);
        issue(2'b10, 32'd999, 32'd3, 1'b0, n);
        repeat (2) @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0;
        repeat (6) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hi", 64'(hi), 64'h1234);
        repeat (40) @(negedge clk);
        check("cancel_hi_late", 64'(hi), 64'h1234);

        // Cancel together with start suppresses the start.
        @(negedge clk);
        op     = 2'b11;
        a      = 32'd50;
        b      = 32'd5;
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_start_busy", 64'(busy), 64'd0);

        // Reset mid-divide, then MTLO.
        issue(2'b10, 32'd77777, 32'd13, 1'b0, n);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h0000ABCD;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_after_rst", 64'(lo), 64'hABCD);

        // Randomised operations.
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: ry = 32'd0;
                1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                2: ry = 32'($urandom_range(1, 15));
                3: rx = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(ro, rx, ry);
        end

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mycpu_muldiv.md
MYCPU_MULDIV -- requirements
Module: myCPU_muldiv

Interface
REQ-001 The block SHALL have no parameters; data width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only while idle.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  first operand (multiplicand / dividend).
REQ-007 b  input  32  second operand (multiplier / divisor).
REQ-008 cancel  input  1  pipeline flush; aborts any operation in flight.
REQ-009 hi_we  input  1  MTHI write strobe.
REQ-010 lo_we  input  1  MTLO write strobe.
REQ-011 wdata  input  32  MTHI/MTLO write data.
REQ-012 busy  output  1  operation in flight; the pipeline stalls MFHI/MFLO while high.
REQ-013 done  output  1  one-cycle pulse marking the completion cycle.
REQ-014 hi  output  32  HI register (high product / remainder).
REQ-015 lo  output  32  LO register (low product / quotient).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, FIX; busy SHALL be high in RUN and FIX only.
REQ-017 In IDLE, start=1 with cancel=0 SHALL latch op and the operand magnitudes (signed ops: two's-complement absolute values), clear a 5-bit iteration counter, and enter RUN.
REQ-018 RUN SHALL perform one iteration per cycle for 32 cycles: radix-2 restoring division for DIV/DIVU, shift-add for MULT/MULTU; the counter wrap 31->0 SHALL move the FSM to FIX.
REQ-019 FIX SHALL apply sign correction, write hi/lo, pulse done for that one cycle, and return to IDLE on the next edge.
REQ-020 Latency SHALL be: start sampled at edge N; hi/lo updated and done high after edge N+33; busy high from edge N+1 through edge N+33; done and busy go low together after edge N+34.
REQ-021 Signed multiply SHALL negate the 64-bit product when a[31]^b[31]=1.
REQ-022 Signed divide SHALL give the quotient sign a[31]^b[31] and the remainder sign a[31].
REQ-023 Divide by zero (b=0), any sign, SHALL give lo=32'hFFFFFFFF and hi=a, with normal latency.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0 (natural wrap, no trap).
REQ-025 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 cancel=1 in RUN or FIX SHALL return to IDLE on the next edge; busy SHALL drop, done SHALL NOT pulse, and hi/lo SHALL stay unchanged.
REQ-027 cancel=1 together with start in IDLE SHALL suppress the start.
REQ-028 hi_we/lo_we SHALL write wdata only in IDLE with start=0; they SHALL be ignored otherwise.
REQ-029 If hi_we and lo_we are both high, both registers SHALL be written.

Reset
REQ-030 reset SHALL force the FSM to IDLE, the counter to 0, hi=0, lo=0, busy=0, and done=0.
REQ-031 reset SHALL take priority over cancel, start, and writes, including mid-operation; no done SHALL follow.

Configuration
REQ-032 Macro MYCPU_MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
REQ-033 With MYCPU_MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL use a single-cycle 64-bit multiply; IDLE SHALL go directly to FIX with busy high one cycle; hi/lo SHALL update and done SHALL pulse after edge N+1.
REQ-034 With MYCPU_MULDIV_FAST_MUL_EN undefined, MULT/MULTU SHALL use the 33-cycle iterative path of REQ-020; division timing SHALL be identical in both builds.

Verification
REQ-035 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, one done pulse at the build-specific latency.
REQ-036 MULT a=-7 (32'hFFFFFFF9), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-037 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
REQ-038 Start DIVU at edge N, then start again at N+5 with different operands -> second start ignored; done exactly once at N+33 with the first result.
REQ-039 Preload hi=32'h1234 via MTHI; start DIV; cancel at N+10 -> busy=0 after N+11, no done, hi=32'h1234.
REQ-040 Assert reset at N+20 of a DIV -> hi=lo=0, busy=0, no done; a subsequent MTLO of 32'hABCD reads back lo=32'hABCD.
